// File: rtl/strmatch_pkg.sv
// Shared constants and types for the CORDIC stream matcher.
//   ATAN_TABLE  : atan(2^-i) in Q.24, i = 0..25
//   CORDIC_INIT : 1/K (CORDIC gain) in Q.24, used as x0 so |x_final| ~ ONE
//   PI_Q, HALF_PI_Q, ONE_Q : Q.24 angle/unit constants
//   state_t     : matcher FSM state encoding
package strmatch_pkg;

    localparam int ATAN_N = 26;

    localparam logic signed [31:0] ATAN_TABLE [0:ATAN_N-1] = '{
        32'sd13176800, 32'sd7778716, 32'sd4110060, 32'sd2086331,
        32'sd1047214,  32'sd524117,  32'sd262123,  32'sd131069,
        32'sd65536,    32'sd32768,   32'sd16384,   32'sd8192,
        32'sd4096,     32'sd2048,    32'sd1024,    32'sd512,
        32'sd256,      32'sd128,     32'sd64,      32'sd32,
        32'sd16,       32'sd8,       32'sd4,       32'sd2,
        32'sd1,        32'sd1
    };

    localparam logic signed [31:0] CORDIC_INIT = 32'sd10188016;
    localparam logic signed [31:0] PI_Q        = 32'sd52707184;
    localparam logic signed [31:0] HALF_PI_Q   = PI_Q >>> 1;
    localparam logic signed [31:0] ONE_Q       = 32'sd16777216;
    localparam int                 FRAC_BITS   = 24;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EVAL_PREP = 3'd1,
        ST_EVAL_ITER = 3'd2,
        ST_EVAL_ACC  = 3'd3,
        ST_DECIDE    = 3'd4
    } state_t;

endpackage

// File: rtl/cordic_rotation_iter.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock.
// Ports:
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_start             : load x0/y0/z0 and begin ITER iterations
//   i_x0, i_y0, i_z0    : initial vector and residual angle (Q.24)
//   o_done              : high in the cycle whose clock edge performs the last
//                         iteration; o_x/o_y are final from the next cycle on
//   o_x, o_y            : current vector
module cordic_rotation_iter
    import strmatch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITER   = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic signed [DATA_W-1:0] i_x0,
    input  logic signed [DATA_W-1:0] i_y0,
    input  logic signed [DATA_W-1:0] i_z0,
    output logic                     o_done,
    output logic signed [DATA_W-1:0] o_x,
    output logic signed [DATA_W-1:0] o_y
);
    localparam int             IW   = 5;
    localparam logic [IW-1:0]  LAST = IW'(ITER - 1);

    logic signed [DATA_W-1:0] r_x, r_y, r_z;
    logic [IW-1:0]            r_i;
    logic                     r_busy;
    logic signed [DATA_W-1:0] w_xs, w_ys, w_atan;
    logic                     w_rot_pos;

    always_comb begin
        w_xs      = r_x >>> r_i;
        w_ys      = r_y >>> r_i;
        w_atan    = DATA_W'(ATAN_TABLE[r_i]);
        w_rot_pos = ~r_z[DATA_W-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_i    <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_x    <= i_x0;
            r_y    <= i_y0;
            r_z    <= i_z0;
            r_i    <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            // Rotate toward z = 0: positive residual rotates counter-clockwise.
            if (w_rot_pos) begin
                r_x <= r_x - w_ys;
                r_y <= r_y + w_xs;
                r_z <= r_z - w_atan;
            end else begin
                r_x <= r_x + w_ys;
                r_y <= r_y - w_xs;
                r_z <= r_z + w_atan;
            end
            if (r_i == LAST) begin
                r_busy <= 1'b0;
            end else begin
                r_i <= r_i + 1'b1;
            end
        end
    end

    assign o_done = r_busy && (r_i == LAST);
    assign o_x    = r_x;
    assign o_y    = r_y;

endmodule

// File: rtl/cordic_stream_matcher.sv
// Streaming binary pattern matcher scored by a time-shared CORDIC engine.
// Each full M-symbol window is scored as sum(cos(text - pattern)) and flagged
// when mismatches <= kmax (and the score agrees).
// Optional build macro: STRMATCH_EARLY_EXIT_EN -- stop scoring a window as soon
// as its mismatch count exceeds kmax.
// Ports:
//   i_clk, i_rst_n               : clock, async active-low reset
//   i_sym_valid/o_sym_ready      : text symbol handshake, i_sym_data symbol bit
//   i_pattern                    : bit 0 compares with the oldest window symbol
//   i_kmax                       : allowed mismatches
//   o_match_valid                : one-cycle result strobe
//   o_match_flag/pos/score       : result, held between strobes
//
// state     | meaning
// IDLE      | accept symbols; start a window once M are held
// EVAL_PREP | form quadrant-folded angle and x0 for element e
// EVAL_ITER | CORDIC engine rotating (ITER cycles)
// EVAL_ACC  | add x_final to the score, count mismatches, advance e
// DECIDE    | strobe the registered result
module cordic_stream_matcher
    import strmatch_pkg::*;
#(
    parameter int M      = 4,
    parameter int ITER   = 24,
    parameter int DATA_W = 32,
    parameter int POS_W  = 16,
    localparam int KW      = $clog2(M + 1),
    localparam int SCORE_W = DATA_W + $clog2(M) + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_sym_valid,
    output logic                      o_sym_ready,
    input  logic                      i_sym_data,
    input  logic [M-1:0]              i_pattern,
    input  logic [KW-1:0]             i_kmax,
    output logic                      o_match_valid,
    output logic                      o_match_flag,
    output logic [POS_W-1:0]          o_match_pos,
    output logic signed [SCORE_W-1:0] o_match_score
);
    localparam int                        EW       = $clog2(M);
    localparam logic [KW-1:0]             FILL_MAX = KW'(M);
    localparam logic [KW-1:0]             FILL_TRG = KW'(M - 1);
    localparam logic [EW-1:0]             E_LAST   = EW'(M - 1);
    localparam logic signed [DATA_W-1:0]  PI_D     = DATA_W'(PI_Q);
    localparam logic signed [DATA_W-1:0]  HPI_D    = DATA_W'(HALF_PI_Q);
    localparam logic signed [DATA_W-1:0]  INIT_D   = DATA_W'(CORDIC_INIT);
    localparam logic signed [SCORE_W-1:0] HALF_ONE = SCORE_W'(ONE_Q >>> 1);

    state_t                    r_state, w_state_nxt;
    logic [M-1:0]              r_win, r_pat;
    logic [KW-1:0]             r_fill, r_kmax, r_mis, w_mis_nxt;
    logic [EW-1:0]             r_e;
    logic [POS_W-1:0]          r_count, r_pos;
    logic signed [SCORE_W-1:0] r_acc, r_score, w_acc_nxt, w_thresh;
    logic [SCORE_W-1:0]        w_thr_u;
    logic                      r_flag, w_flag_nxt, w_accept, w_start, w_done, w_early;
    logic signed [DATA_W-1:0]  w_delta, w_x0, w_z0, w_x, w_y_unused;

    cordic_rotation_iter #(.DATA_W(DATA_W), .ITER(ITER)) u_cordic (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_start),
        .i_x0    (w_x0),
        .i_y0    ('0),
        .i_z0    (w_z0),
        .o_done  (w_done),
        .o_x     (w_x),
        .o_y     (w_y_unused)
    );

    assign w_accept = (r_state == ST_IDLE) && i_sym_valid;

    // Element angle difference, folded into [-pi/2, pi/2] so the CORDIC
    // converges; the lost half-turn is restored by negating x0.
    always_comb begin
        w_delta = '0;
        if (r_win[r_e]) w_delta = w_delta + PI_D;
        if (r_pat[r_e]) w_delta = w_delta - PI_D;
        w_z0 = w_delta;
        w_x0 = INIT_D;
        if (w_delta > HPI_D) begin
            w_z0 = w_delta - PI_D;
            w_x0 = -INIT_D;
        end else if (w_delta < -HPI_D) begin
            w_z0 = w_delta + PI_D;
            w_x0 = -INIT_D;
        end
    end

    always_comb begin
        w_acc_nxt = r_acc + {{(SCORE_W-DATA_W){w_x[DATA_W-1]}}, w_x};
        w_mis_nxt = r_mis + {{(KW-1){1'b0}}, w_x[DATA_W-1]};
        // (M - 2K) * ONE - ONE/2, formed in two's complement at score width
        w_thr_u   = (SCORE_W'(M) - (SCORE_W'(r_kmax) << 1)) << FRAC_BITS;
        w_thresh  = $signed(w_thr_u) - HALF_ONE;
        w_flag_nxt = (r_kmax >= FILL_MAX) ||
                     ((w_mis_nxt <= r_kmax) && (w_acc_nxt >= w_thresh));
`ifdef STRMATCH_EARLY_EXIT_EN
        w_early = (w_mis_nxt > r_kmax);
`else
        w_early = 1'b0;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_accept && (r_fill >= FILL_TRG)) w_state_nxt = ST_EVAL_PREP;
            ST_EVAL_PREP: begin
                w_start     = 1'b1;
                w_state_nxt = ST_EVAL_ITER;
            end
            ST_EVAL_ITER: if (w_done) w_state_nxt = ST_EVAL_ACC;
            ST_EVAL_ACC:  w_state_nxt = ((r_e == E_LAST) || w_early) ? ST_DECIDE : ST_EVAL_PREP;
            ST_DECIDE:    w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_win   <= '0;
            r_pat   <= '0;
            r_fill  <= '0;
            r_kmax  <= '0;
            r_mis   <= '0;
            r_e     <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_flag  <= 1'b0;
            r_pos   <= '0;
            r_score <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_win   <= {i_sym_data, r_win[M-1:1]};
                r_count <= r_count + 1'b1;
                if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
                if (w_state_nxt == ST_EVAL_PREP) begin
                    r_pat  <= i_pattern;
                    r_kmax <= i_kmax;
                    r_acc  <= '0;
                    r_mis  <= '0;
                    r_e    <= '0;
                end
            end
            if (r_state == ST_EVAL_ACC) begin
                r_acc <= w_acc_nxt;
                r_mis <= w_mis_nxt;
                r_e   <= r_e + 1'b1;
                if (w_state_nxt == ST_DECIDE) begin
                    r_flag  <= w_flag_nxt;
                    r_score <= w_acc_nxt;
                    r_pos   <= r_count - POS_W'(M);
                end
            end
        end
    end

    assign o_sym_ready   = (r_state == ST_IDLE);
    assign o_match_valid = (r_state == ST_DECIDE);
    assign o_match_flag  = r_flag;
    assign o_match_pos   = r_pos;
    assign o_match_score = r_score;

endmodule
